// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES controller receiver.
package snes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } snes_state_t;

  localparam int SNES_BITS = 16;

  // Button positions within the received word (bit 0 is shifted first)
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

endpackage

// File: rtl/snes_receiver_if.sv
// Controller pins, interrupt handshake and decoded frame outputs of the SNES receiver.
interface snes_receiver_if;
  import snes_pkg::*;

  logic                 data_latch;
  logic                 data_clock;
  logic                 serial_data;
  logic                 irq_ack;
  logic [SNES_BITS-1:0] buttons;
  logic                 frame_valid;
  logic                 irq;
  logic                 frame_err;

  modport master (
    output data_latch, data_clock, serial_data, irq_ack,
    input  buttons, frame_valid, irq, frame_err
  );

  modport slave (
    input  data_latch, data_clock, serial_data, irq_ack,
    output buttons, frame_valid, irq, frame_err
  );

endinterface

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, with one-cycle rise/fall strobes.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Reset to the line's idle level so releasing reset never fakes an edge
  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/snes_receiver.sv
// SNES controller receiver: frames 16 serial bits between latch pulses into a button word,
// flags changes with a sticky interrupt and aborts on re-latch or timeout.
module snes_receiver
  import snes_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic            clk,
  input  logic            rst_n,
  snes_receiver_if.slave  bus
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic latch_rise, latch_fall, latch_level_unused;
  logic clk_fall, clk_rise_unused, clk_level_unused;
  logic data_sync, data_rise_unused, data_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_latch (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.data_latch),
    .dout (latch_level_unused),
    .rise (latch_rise),
    .fall (latch_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clock (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.data_clock),
    .dout (clk_level_unused),
    .rise (clk_rise_unused),
    .fall (clk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_data (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.serial_data),
    .dout (data_sync),
    .rise (data_rise_unused),
    .fall (data_fall_unused)
  );

  snes_state_t          state_q;
  logic [4:0]           count_q;
  logic [TW-1:0]        tmo_q;
  logic [SNES_BITS-1:0] shift_q;
  logic [SNES_BITS-1:0] buttons_q;
  logic                 chg_q;
  logic                 frame_valid_q;
  logic                 frame_err_q;
  logic                 irq_q;

  logic [SNES_BITS-1:0] next_word;
  logic                 last_bit;
  logic                 set_irq;

  // Word as it stands once the 16th (active-low) bit is folded in
  assign next_word = {~data_sync, shift_q[SNES_BITS-2:0]};
  assign last_bit  = (count_q == 5'(SNES_BITS - 1));
  assign set_irq   = (state_q == ST_DONE) && chg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      tmo_q         <= '0;
      shift_q       <= '0;
      buttons_q     <= '0;
      chg_q         <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;

      // A change landing in the same cycle as an acknowledge must not be lost
      if (set_irq)          irq_q <= 1'b1;
      else if (bus.irq_ack) irq_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (latch_rise) state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          if (latch_fall) begin
            state_q <= ST_SHIFT;
            count_q <= '0;
            tmo_q   <= '0;
            shift_q <= '0;
          end
        end
        ST_SHIFT: begin
          // Re-latch beats a completing bit, which beats the timeout
          if (latch_rise) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_LATCH;
          end else if (clk_fall && last_bit) begin
            shift_q       <= next_word;
            count_q       <= count_q + 5'd1;
            buttons_q     <= next_word;
            frame_valid_q <= 1'b1;
            chg_q         <= (next_word != buttons_q);
            state_q       <= ST_DONE;
          end else if (tmo_q == TMO_LAST) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (clk_fall) begin
              shift_q[count_q[3:0]] <= ~data_sync;
              count_q               <= count_q + 5'd1;
            end
          end
        end
        ST_DONE: begin
          state_q <= latch_rise ? ST_LATCH : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.buttons     = buttons_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.irq         = irq_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_snes_receiver.sv
// Self-checking bench for snes_receiver: table vectors, random frames against a
// frame-level model, and hand-written abort/timeout/reset sequences.
module tb_snes_receiver;
  import snes_pkg::*;

  localparam int SYNC = 2;
  localparam int TMO  = 600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snes_receiver_if bus ();

  snes_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  bit ack_req = 0;
  bit ack_on_fv = 0;

  logic [15:0] model_buttons = 16'h0000;
  bit          model_irq = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_valid) fv_cnt++;
      if (bus.frame_err)   err_cnt++;
    end
  end

  // Sole driver of irq_ack: one-cycle pulses on request or on a seen frame_valid
  initial begin
    bus.irq_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.irq_ack) bus.irq_ack = 1'b0;
      else if (ack_req) begin
        bus.irq_ack = 1'b1;
        ack_req = 0;
      end else if (ack_on_fv && bus.frame_valid) begin
        bus.irq_ack = 1'b1;
        ack_on_fv = 0;
      end
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: cycles %0d, required finish before 100000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_latch();
    @(negedge clk);
    bus.data_latch = 1'b1;
    wait_cyc(6);
    bus.data_latch = 1'b0;
    wait_cyc(6);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bus.serial_data = ~w[i];
      wait_cyc(4);
      bus.data_clock = 1'b0;
      wait_cyc(4);
      bus.data_clock = 1'b1;
      wait_cyc(2);
    end
    bus.serial_data = 1'b1;
  endtask

  // Frame-level reference: ack clears, any changed word sets, repeats leave irq alone
  task automatic model_step(input logic [15:0] w, input bit ack);
    if (ack) model_irq = 0;
    if (w != model_buttons) model_irq = 1;
    model_buttons = w;
  endtask

  task automatic run_frame(input logic [15:0] w, input bit ack_before,
                           input logic [15:0] exp_b, input bit exp_irq, input string tag);
    int v0, e0;
    if (ack_before) begin
      ack_req = 1;
      wait_cyc(3);
    end
    v0 = fv_cnt;
    e0 = err_cnt;
    send_latch();
    send_bits(w, 16);
    wait_cyc(8);
    check({tag, " buttons"}, int'(bus.buttons), int'(exp_b));
    check({tag, " irq"}, int'(bus.irq), int'(exp_irq));
    check({tag, " frame_valid pulses"}, fv_cnt - v0, 1);
    check({tag, " frame_err pulses"}, err_cnt - e0, 0);
  endtask

  typedef struct {
    logic [15:0] word;
    bit          ack_before;
    logic [15:0] exp_buttons;
    bit          exp_irq;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int v0, e0, t0, elapsed;
    logic [15:0] w, b0;
    bit ack, seen;

    vecs[0] = '{16'h0F0A, 1'b0, 16'h0F0A, 1'b1};
    vecs[1] = '{16'h0F0A, 1'b1, 16'h0F0A, 1'b0};
    vecs[2] = '{16'h0000, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[4] = '{16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h8001, 1'b0, 16'h8001, 1'b1};
    vecs[6] = '{16'h8001, 1'b1, 16'h8001, 1'b0};
    vecs[7] = '{16'h0108, 1'b1, 16'h0108, 1'b1};

    bus.data_latch  = 1'b0;
    bus.data_clock  = 1'b1;
    bus.serial_data = 1'b1;
    rst_n = 1'b0;
    wait_cyc(5);
    check("reset buttons", int'(bus.buttons), 0);
    check("reset irq", int'(bus.irq), 0);
    check("reset frame_valid", int'(bus.frame_valid), 0);
    check("reset frame_err", int'(bus.frame_err), 0);
    rst_n = 1'b1;
    wait_cyc(5);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].word, vecs[i].ack_before, vecs[i].exp_buttons, vecs[i].exp_irq,
                $sformatf("vec%0d", i));
      model_step(vecs[i].word, vecs[i].ack_before);
    end

    for (int i = 0; i < 16; i++) begin
      w   = ($urandom_range(0, 3) == 0) ? model_buttons : 16'($urandom);
      ack = ($urandom_range(0, 1) == 1);
      model_step(w, ack);
      run_frame(w, ack, model_buttons, model_irq, $sformatf("rand%0d", i));
    end

    // Re-latch after 7 bits aborts; the new latch then carries a full frame
    ack_req = 1;
    wait_cyc(3);
    b0 = bus.buttons;
    v0 = fv_cnt;
    e0 = err_cnt;
    send_latch();
    send_bits(16'h5555, 7);
    send_latch();
    wait_cyc(2);
    check("abort frame_err", err_cnt - e0, 1);
    check("abort buttons kept", int'(bus.buttons), int'(b0));
    check("abort no frame_valid", fv_cnt - v0, 0);
    send_bits(16'h0001, 16);
    wait_cyc(8);
    model_step(16'h0001, 1'b1);
    check("after abort buttons", int'(bus.buttons), int'(model_buttons));
    check("after abort frame_valid", fv_cnt - v0, 1);
    check("after abort irq", int'(bus.irq), int'(model_irq));

    // Short frame with no re-latch: timeout abort roughly TMO cycles after latch fall
    b0 = bus.buttons;
    v0 = fv_cnt;
    e0 = err_cnt;
    @(negedge clk);
    bus.data_latch = 1'b1;
    wait_cyc(6);
    bus.data_latch = 1'b0;
    t0 = cyc;
    send_bits(16'h00FF, 10);
    seen = 0;
    elapsed = 0;
    while (!seen && (cyc - t0) < TMO + 50) begin
      @(negedge clk);
      if (bus.frame_err) begin
        seen = 1;
        elapsed = cyc - t0;
      end
    end
    check("timeout frame_err seen", int'(seen), 1);
    check("timeout latency in window",
          int'(elapsed >= TMO && elapsed <= TMO + SYNC + 4), 1);
    wait_cyc(4);
    send_bits(16'hFFFF, 4);
    wait_cyc(8);
    check("timeout buttons kept", int'(bus.buttons), int'(b0));
    check("timeout no frame_valid", fv_cnt - v0, 0);
    check("timeout single frame_err", err_cnt - e0, 1);
    model_step(16'h3C3C, 1'b0);
    run_frame(16'h3C3C, 1'b0, model_buttons, model_irq, "post timeout");

    // Acknowledge landing in the frame's completion cycle must not swallow the new irq
    ack_req = 1;
    wait_cyc(3);
    check("pre-ack irq cleared", int'(bus.irq), 0);
    ack_on_fv = 1;
    w = ~model_buttons;
    send_latch();
    send_bits(w, 16);
    wait_cyc(8);
    model_step(w, 1'b0);
    check("done-ack fired", int'(ack_on_fv), 0);
    check("done-ack irq", int'(bus.irq), 1);
    check("done-ack buttons", int'(bus.buttons), int'(model_buttons));

    // Reset during bit 9 discards everything; next frame decodes from scratch
    send_latch();
    send_bits(16'hA5A5, 8);
    bus.serial_data = 1'b0;
    wait_cyc(4);
    bus.data_clock = 1'b0;
    wait_cyc(1);
    rst_n = 1'b0;
    wait_cyc(2);
    check("midreset buttons", int'(bus.buttons), 0);
    check("midreset irq", int'(bus.irq), 0);
    check("midreset frame_valid", int'(bus.frame_valid), 0);
    check("midreset frame_err", int'(bus.frame_err), 0);
    bus.data_clock  = 1'b1;
    bus.serial_data = 1'b1;
    wait_cyc(3);
    v0 = fv_cnt;
    e0 = err_cnt;
    rst_n = 1'b1;
    send_bits(16'h0003, 4);
    wait_cyc(20);
    check("post-reset no frame_valid", fv_cnt - v0, 0);
    check("post-reset no frame_err", err_cnt - e0, 0);
    model_buttons = 16'h0000;
    model_irq = 0;
    model_step(16'h0A50, 1'b0);
    run_frame(16'h0A50, 1'b0, model_buttons, model_irq, "post reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
